// File: rtl/gray_seq_ctrl_if.sv
// Stream/control bundle for gray_seq_ctrl; the sequencer attaches through the slave modport.
// The optional loop input exists only when GRAY_SEQ_LOOP_EN is defined.
interface gray_seq_ctrl_if #(
    parameter int W = 4
);
    logic         start;
    logic         abort;
    logic         dir;
    logic [W-1:0] first;
    logic [W-1:0] last;
`ifdef GRAY_SEQ_LOOP_EN
    logic         loop;
`endif
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_bin;
    logic [W-1:0] out_gray;
    logic         out_last;
    logic         busy;
    logic         done;

    modport master (
        output start, abort, dir, first, last,
`ifdef GRAY_SEQ_LOOP_EN
        loop,
`endif
        out_ready,
        input  out_valid, out_bin, out_gray, out_last, busy, done
    );

    modport slave (
        input  start, abort, dir, first, last,
`ifdef GRAY_SEQ_LOOP_EN
        loop,
`endif
        out_ready,
        output out_valid, out_bin, out_gray, out_last, busy, done
    );
endinterface

// File: rtl/gray_seq_ctrl.sv
// Steps a binary index from first to last (up/down, modulo 2^W) and streams index + Gray code.
// Optional feature macro: GRAY_SEQ_LOOP_EN (adds a latched loop input that restarts at first).
module gray_seq_ctrl #(
    parameter int W = 4
) (
    input  logic            clk,
    input  logic            rst,
    gray_seq_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [W-1:0] ONE = W'(1);

    function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    state_t       state_q;
    logic [W-1:0] idx_q;
    logic [W-1:0] gray_q;
    logic         valid_q;
    logic         busy_q;
    logic         done_q;
    logic         last_flag_q;

    logic [W-1:0] first_q;
    logic [W-1:0] last_q;
    logic         dir_q;
    logic         loop_q;

    logic [W-1:0] idx_d;
    logic [W-1:0] lim_d;
    logic         load_d;
    logic         hs_d;
    logic         at_last_d;

    assign load_d = (state_q == IDLE) && bus.start && !bus.abort;

    // Sequence parameters are captured once per start and held for the whole run.
    always_ff @(posedge clk) begin
        if (load_d) begin
            first_q <= bus.first;
            last_q  <= bus.last;
            dir_q   <= bus.dir;
`ifdef GRAY_SEQ_LOOP_EN
            loop_q  <= bus.loop;
`else
            loop_q  <= 1'b0;
`endif
        end
    end

    always_comb begin
        hs_d      = valid_q && bus.out_ready;
        at_last_d = (idx_q == last_q);
        idx_d     = idx_q;
        lim_d     = last_q;
        if (load_d) begin
            idx_d = bus.first;
            lim_d = bus.last;
        end else if (state_q == EMIT && hs_d && !bus.abort) begin
            if (!at_last_d) begin
                idx_d = dir_q ? (idx_q - ONE) : (idx_q + ONE);
            end else if (loop_q) begin
                idx_d = first_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            gray_q      <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            last_flag_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            gray_q <= to_gray(idx_d);
            // Abort outranks everything, including a handshake in the same cycle.
            if (bus.abort) begin
                state_q     <= IDLE;
                valid_q     <= 1'b0;
                busy_q      <= 1'b0;
                done_q      <= 1'b0;
                last_flag_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        done_q <= 1'b0;
                        if (bus.start) begin
                            state_q     <= EMIT;
                            valid_q     <= 1'b1;
                            busy_q      <= 1'b1;
                            last_flag_q <= (idx_d == lim_d);
                        end
                    end
                    EMIT: begin
                        if (hs_d) begin
                            if (at_last_d && !loop_q) begin
                                state_q     <= DONE;
                                valid_q     <= 1'b0;
                                done_q      <= 1'b1;
                                last_flag_q <= 1'b0;
                            end else begin
                                last_flag_q <= (idx_d == lim_d);
                            end
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q     <= IDLE;
                        valid_q     <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b0;
                        last_flag_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_bin   = idx_q;
    assign bus.out_gray  = gray_q;
    assign bus.out_last  = last_flag_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Scoreboard bench for gray_seq_ctrl: directed sequences push expected codes, a monitor pops them.
module tb_gray_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    gray_seq_ctrl_if #(.W(4)) bus ();

    gray_seq_ctrl #(.W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0] bin;
        logic [3:0] gray;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk    = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;

    task automatic check(input string nm, input int act, input int req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic void push(input logic [3:0] b, input logic [3:0] g, input logic l);
        exp_t e;
        e.bin  = b;
        e.gray = g;
        e.last = l;
        exp_q.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: one pop per accepted transfer; an aborted cycle is not a transfer.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.done) done_cnt++;
            if (bus.out_valid && bus.out_ready && !bus.abort) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_code", int'(bus.out_bin), -1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("code_bin",  int'(bus.out_bin),  int'(e.bin));
                    check("code_gray", int'(bus.out_gray), int'(e.gray));
                    check("code_last", int'(bus.out_last), int'(e.last));
                end
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (!bus.busy) break;
            tick();
        end
        check("idle_reached", int'(bus.busy), 0);
    endtask

    task automatic run_seq(input logic [3:0] f, input logic [3:0] l, input logic d);
        int d0;
        d0 = done_cnt;
        bus.first = f;
        bus.last  = l;
        bus.dir   = d;
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_idle();
        check("queue_drained", exp_q.size(), 0);
        check("done_once", done_cnt - d0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int d0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.dir   = 1'b0;
        bus.first = '0;
        bus.last  = '0;
        bus.out_ready = 1'b1;
`ifdef GRAY_SEQ_LOOP_EN
        bus.loop  = 1'b0;
`endif
        #2;
        check("rst_valid", int'(bus.out_valid), 0);
        check("rst_bin",   int'(bus.out_bin),   0);
        check("rst_gray",  int'(bus.out_gray),  0);
        check("rst_last",  int'(bus.out_last),  0);
        check("rst_busy",  int'(bus.busy),      0);
        check("rst_done",  int'(bus.done),      0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Basic 0..3 with exact cycle timing
        push(4'd0, 4'b0000, 1'b0);
        push(4'd1, 4'b0001, 1'b0);
        push(4'd2, 4'b0011, 1'b0);
        push(4'd3, 4'b0010, 1'b1);
        d0 = done_cnt;
        bus.first = 4'd0; bus.last = 4'd3; bus.dir = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("lat_valid", int'(bus.out_valid), 1);
        check("lat_bin",   int'(bus.out_bin),   0);
        tick(); tick(); tick();
        check("c4_last", int'(bus.out_last), 1);
        tick();
        check("c5_done",  int'(bus.done),      1);
        check("c5_valid", int'(bus.out_valid), 0);
        check("c5_busy",  int'(bus.busy),      1);
        tick();
        check("c6_done", int'(bus.done), 0);
        check("c6_busy", int'(bus.busy), 0);
        check("basic_drained", exp_q.size(), 0);
        check("basic_done_cnt", done_cnt - d0, 1);

        // Up-wrap 14 -> 1
        push(4'd14, 4'b1001, 1'b0);
        push(4'd15, 4'b1000, 1'b0);
        push(4'd0,  4'b0000, 1'b0);
        push(4'd1,  4'b0001, 1'b1);
        run_seq(4'd14, 4'd1, 1'b0);

        // Down-wrap 2 -> 15
        push(4'd2,  4'b0011, 1'b0);
        push(4'd1,  4'b0001, 1'b0);
        push(4'd0,  4'b0000, 1'b0);
        push(4'd15, 4'b1000, 1'b1);
        run_seq(4'd2, 4'd15, 1'b1);

        // Backpressure: hold code 4 for three cycles
        d0 = done_cnt;
        bus.out_ready = 1'b0;
        bus.first = 4'd4; bus.last = 4'd5; bus.dir = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", int'(bus.out_valid), 1);
            check("stall_bin",   int'(bus.out_bin),   4);
            check("stall_gray",  int'(bus.out_gray),  6);
            if (i < 2) tick();
        end
        push(4'd4, 4'b0110, 1'b0);
        push(4'd5, 4'b0111, 1'b1);
        bus.out_ready = 1'b1;
        wait_idle();
        check("bp_drained", exp_q.size(), 0);
        check("bp_done_cnt", done_cnt - d0, 1);

        // Single code first = last = 9
        push(4'd9, 4'b1101, 1'b1);
        run_seq(4'd9, 4'd9, 1'b0);

        // Abort on the cycle presenting code 2
        d0 = done_cnt;
        push(4'd0, 4'b0000, 1'b0);
        push(4'd1, 4'b0001, 1'b0);
        bus.first = 4'd0; bus.last = 4'd5; bus.dir = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick();
        check("abort_at_code2", int'(bus.out_bin), 2);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_valid", int'(bus.out_valid), 0);
        check("abort_busy",  int'(bus.busy),      0);
        tick(); tick();
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_drained", exp_q.size(), 0);

        // Asynchronous reset in the middle of EMIT
        bus.out_ready = 1'b0;
        bus.first = 4'd3; bus.last = 4'd7;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("pre_rst_valid", int'(bus.out_valid), 1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", int'(bus.out_valid), 0);
        check("arst_bin",   int'(bus.out_bin),   0);
        check("arst_gray",  int'(bus.out_gray),  0);
        check("arst_last",  int'(bus.out_last),  0);
        check("arst_busy",  int'(bus.busy),      0);
        check("arst_done",  int'(bus.done),      0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("post_rst_idle", int'(bus.busy), 0);

`ifdef GRAY_SEQ_LOOP_EN
        // Loop mode repeats 0,1 until aborted
        d0 = done_cnt;
        push(4'd0, 4'b0000, 1'b0);
        push(4'd1, 4'b0001, 1'b1);
        push(4'd0, 4'b0000, 1'b0);
        push(4'd1, 4'b0001, 1'b1);
        bus.loop  = 1'b1;
        bus.first = 4'd0; bus.last = 4'd1; bus.dir = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.loop  = 1'b0;
        tick(); tick(); tick(); tick();
        check("loop_still_valid", int'(bus.out_valid), 1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("loop_abort_busy", int'(bus.busy), 0);
        check("loop_no_done", done_cnt - d0, 0);
        check("loop_drained", exp_q.size(), 0);
`endif

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
